// File: rtl/mem_pipe_rw_pkg.sv
// Shared types and sizing helpers for the pipelined read/write memory.
package mem_pipe_pkg;

    // Encoding matches the {read, write} pair so it can be decoded by a cast.
    typedef enum logic [1:0] {
        CMD_IDLE = 2'b00,
        CMD_RD   = 2'b10,
        CMD_WR   = 2'b01,
        CMD_ILL  = 2'b11
    } cmd_e;

    function automatic int unsigned depth_f(input int unsigned rd_lat);
        return rd_lat + 1;
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_pipe_rw_if.sv
// Request/response bus between the test side (master) and the memory (slave).
interface mem_pipe_rw_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] rsp_addr;
    logic              err;

    modport master (
        output req_valid, read, write, addr, data_in, rsp_ready,
        input  req_ready, rsp_valid, data_out, rsp_addr, err
    );

    modport slave (
        input  req_valid, read, write, addr, data_in, rsp_ready,
        output req_ready, rsp_valid, data_out, rsp_addr, err
    );
endinterface

// File: rtl/mem_pipe_rw_rsp_fifo.sv
// Circular-buffer FIFO holding read responses until the consumer takes them.
module mem_rsp_fifo
    import mem_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic [7:0]
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output T                             head,
    output logic [cnt_w_f(DEPTH)-1:0]    count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_w_f(DEPTH);

    T                 store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end

    assign head = store[rd_ptr];
endmodule

// File: rtl/mem_pipe_rw.sv
// Single-port memory with configurable read latency, credit-based request
// flow control and an ordered, back-pressurable response FIFO.
module mem_pipe_rw
    import mem_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_pipe_rw_if.slave  bus
);
    localparam int unsigned DEPTH = depth_f(RD_LAT);
    localparam int unsigned CNT_W = cnt_w_f(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rsp_t;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_check
        $error("mem_pipe_rw: RD_LAT=%0d outside legal range 1..4", RD_LAT);
    end

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    cmd_e              cmd;
    logic              req_ready;
    logic              rsp_valid;
    logic              accept;
    logic              rd_acc;
    logic              pop;
    logic              push;
    logic              err_q;
    rsp_t              rd_word;
    rsp_t              push_word;
    rsp_t              head;

    assign cmd       = cmd_e'({bus.read, bus.write});
    assign req_ready = inflight < CNT_W'(DEPTH);
    assign accept    = bus.req_valid && req_ready;
    assign rd_acc    = accept && (cmd == CMD_RD);
    assign rd_word   = '{addr: bus.addr, data: mem[bus.addr]};
    assign rsp_valid = fifo_count != '0;
    assign pop       = rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk) begin
        if (accept && cmd == CMD_WR) mem[bus.addr] <= bus.data_in;
    end

    // Credits cover both pipeline stages and FIFO slots, so the FIFO never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            err_q    <= 1'b0;
        end else begin
            inflight <= inflight + CNT_W'(rd_acc) - CNT_W'(pop);
            err_q    <= accept && (cmd == CMD_ILL);
        end
    end

    // Array read is captured at the accept edge; RD_LAT-1 further stages
    // precede the FIFO, which itself provides the final registered stage.
    if (RD_LAT == 1) begin : g_direct
        assign push      = rd_acc;
        assign push_word = rd_word;
    end else begin : g_pipe
        logic [RD_LAT-2:0] stage_v;
        rsp_t              stage_q [RD_LAT-1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_v <= '0;
            end else begin
                stage_v[0] <= rd_acc;
                for (int unsigned i = 1; i < RD_LAT - 1; i++) stage_v[i] <= stage_v[i-1];
            end
        end

        always_ff @(posedge clk) begin
            stage_q[0] <= rd_word;
            for (int unsigned i = 1; i < RD_LAT - 1; i++) stage_q[i] <= stage_q[i-1];
        end

        assign push      = stage_v[RD_LAT-2];
        assign push_word = stage_q[RD_LAT-2];
    end

    mem_rsp_fifo #(
        .DEPTH (DEPTH),
        .T     (rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.data_out  = rsp_valid ? head.data : '0;
    assign bus.rsp_addr  = rsp_valid ? head.addr : '0;
    assign bus.err       = err_q;
endmodule

// File: doc/mem_pipe_rw.md
Name: mem_pipe_rw

Overview:
- Parametrised single-port synchronous memory with valid/ready request and response channels.
- Successor to the fixed 32x8 read/write test memory. Generalises address and data width, adds a configurable read latency, back-pressure on responses and illegal-command detection.
- Sits behind the test-to-memory interface; the bench drives requests and consumes ordered read responses.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W words.
- DATA_W, 8, data word width.
- RD_LAT, 1, read latency in cycles from request acceptance to rsp_valid, with no back-pressure; legal range 1..4.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- read  input  1  read command; qualified by req_valid.
- write  input  1  write command; qualified by req_valid.
- addr  input  ADDR_W  word address.
- data_in  input  DATA_W  write data.
- rsp_valid  output  1  read response present.
- rsp_ready  input  1  consumer accepts the response.
- data_out  output  DATA_W  read data.
- rsp_addr  output  ADDR_W  address of the returned read.
- err  output  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, data_out=0, rsp_addr=0, err=0. Pipeline valids, FIFO and credit counter are cleared. Memory array is not reset; contents are retained across reset.
- Accept: a request is accepted on a posedge with req_valid && req_ready.
- req_ready = (inflight < DEPTH), where DEPTH = RD_LAT+1 and inflight = read-pipeline occupancy + FIFO count. It depends only on registered state, never on req_* inputs, and gates all commands.
- Write (write=1, read=0): mem[addr] <= data_in on the accepting edge. Produces no response and consumes no credit.
- Read (read=1, write=0): data is sampled from the array on the accepting edge and travels through RD_LAT-1 pipeline registers. It then enters the response FIFO (DEPTH entries) with its addr.
  - With no back-pressure, rsp_valid rises exactly RD_LAT cycles after the accept edge.
  - Throughput is one read per cycle when rsp_ready=1.
- Ordering: responses are returned strictly in acceptance order.
- Read-after-write to the same address on the next accepted cycle returns the new data. A read accepted on edge k+1 after a write on edge k sees the written value.
- Illegal command (read=1 and write=1): the handshake completes and err=1 for the cycle after the edge. Memory is unchanged, no response is produced and no credit is consumed.
- Idle command (both 0) with req_valid: accepted, no effect.
- Response handshake: pop on posedge with rsp_valid && rsp_ready. While rsp_valid && !rsp_ready, data_out and rsp_addr hold stable.
- Simultaneous push and pop in one cycle: FIFO count unchanged; inflight updated by accept(+1) minus pop(-1).
- Full: with inflight==DEPTH, req_ready=0. A pop re-asserts req_ready in the following cycle.
- Address wrap: none internally; addr is used modulo 2**ADDR_W by width.
- Reset mid-operation: all in-flight reads and queued responses are dropped, and rsp_valid deasserts asynchronously.
- Static check: RD_LAT outside 1..4 triggers an elaboration-time $error.

Decomposition:
- Package mem_pipe_pkg:
  - cmd_e enum {CMD_IDLE, CMD_RD, CMD_WR, CMD_ILL} decoded from {read, write}.
  - rsp_t struct {addr, data}.
  - Function depth_f(RD_LAT) returning RD_LAT+1.
  - Function clog2-based counter width for inflight.
- Sub-module mem_rsp_fifo: parametrised synchronous FIFO of rsp_t with DEPTH entries, push/pop, and count output, on the same clk/rst_n.

Test Plan (ADDR_W=5, DATA_W=8, RD_LAT=2 unless stated):
- Write 0x41 to addr 3, then read addr 3 on the next cycle with rsp_ready=1 -> rsp_valid high exactly 2 cycles after read accept, data_out=0x41, rsp_addr=3.
- Back-to-back reads of addrs 0..7 (preloaded 0x10..0x17), rsp_ready=1 -> eight consecutive rsp_valid cycles, data 0x10..0x17 in order, req_ready never drops.
- rsp_ready=0, issue reads to addrs 0..4 -> exactly 3 accepted, then req_ready=0. Raising rsp_ready returns all 3 in order, data stable while stalled, and remaining reads proceed.
- read=1, write=1, addr 5, data_in 0xFF -> err pulses for 1 cycle, no response, and a subsequent read of addr 5 returns its prior value.
- Two reads in flight, assert rst_n=0 for 1 cycle -> rsp_valid=0 immediately, no stale responses after reset. Memory retains 0x41 at addr 3 on re-read.
- ADDR_W=6, DATA_W=16, RD_LAT=4: write 0xBEEF to addr 63, read it -> 0xBEEF after 4 cycles, rsp_addr=63.
